// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: fetch handshake, register-file and ALU control bundle of instr_sequencer
interface instr_sequencer_if #(
   parameter int D_WIDTH = 32,
   parameter int A_WIDTH = 5
);
   logic [D_WIDTH-1:0] pc;
   logic               fetch_req;
   logic [D_WIDTH-1:0] instr;
   logic               instr_valid;
   logic [A_WIDTH-1:0] ad1;
   logic [A_WIDTH-1:0] ad2;
   logic [A_WIDTH-1:0] ad3;
   logic               we3;
   logic [D_WIDTH-1:0] imm_op;
   logic               alusrc;
   logic [2:0]         aluctrl;
   logic               eq;
   logic               illegal;

   modport master (
      output pc, fetch_req, ad1, ad2, ad3, we3, imm_op, alusrc, aluctrl, illegal,
      input  instr, instr_valid, eq
   );

   modport slave (
      input  pc, fetch_req, ad1, ad2, ad3, we3, imm_op, alusrc, aluctrl, illegal,
      output instr, instr_valid, eq
   );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute sequencer for addi, add, sub, beq (bne when INSTR_SEQUENCER_BNE_EN is defined)
module instr_sequencer #(
   parameter int                 D_WIDTH  = 32,
   parameter int                 A_WIDTH  = 5,
   parameter logic [D_WIDTH-1:0] RESET_PC = '0
) (
   input logic               clk,
   input logic               rst,
   instr_sequencer_if.master bus
);
   typedef enum logic [1:0] {FETCH, DECODE, EXEC, TRAP} state_t;
   typedef enum logic [2:0] {OP_ADDI, OP_ADD, OP_SUB, OP_BEQ, OP_BNE} op_t;

   state_t             state_q, state_d;
   op_t                op_q, op_d;
   logic [D_WIDTH-1:0] pc_q, pc_d;
   logic [D_WIDTH-1:0] ir_q, ir_d;
   logic [D_WIDTH-1:0] imm_q, imm_d;
   logic               illegal_q, illegal_d;

   logic [6:0]         opcode;
   logic [2:0]         funct3;
   logic [6:0]         funct7;
   logic               bne_ok;
   logic               is_i, is_b;
   logic               is_addi, is_add, is_sub, is_beq, is_bne, legal;
   logic [D_WIDTH-1:0] imm_i, imm_b;
   logic               writes_rd, taken;

`ifdef INSTR_SEQUENCER_BNE_EN
   assign bne_ok = 1'b1;
`else
   assign bne_ok = 1'b0;
`endif

   assign opcode  = ir_q[6:0];
   assign funct3  = ir_q[14:12];
   assign funct7  = ir_q[31:25];
   assign is_i    = opcode == 7'b0010011;
   assign is_b    = opcode == 7'b1100011;
   assign is_addi = is_i && funct3 == 3'b000;
   assign is_add  = opcode == 7'b0110011 && funct3 == 3'b000 && funct7 == 7'b0000000;
   assign is_sub  = opcode == 7'b0110011 && funct3 == 3'b000 && funct7 == 7'b0100000;
   assign is_beq  = is_b && funct3 == 3'b000;
   assign is_bne  = is_b && funct3 == 3'b001 && bne_ok;
   assign legal   = is_addi || is_add || is_sub || is_beq || is_bne;
   assign imm_i   = {{(D_WIDTH-12){ir_q[31]}}, ir_q[31:20]};
   assign imm_b   = {{(D_WIDTH-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

   assign writes_rd = op_q == OP_ADDI || op_q == OP_ADD || op_q == OP_SUB;
   assign taken     = (op_q == OP_BEQ && bus.eq) || (op_q == OP_BNE && !bus.eq);

   assign bus.ad1     = ir_q[19:15];
   assign bus.ad2     = ir_q[24:20];
   assign bus.ad3     = ir_q[11:7];
   assign bus.pc      = pc_q;
   assign bus.imm_op  = imm_q;
   assign bus.illegal = illegal_q;

   // State register; reset is asynchronous so an in-flight EXEC never commits its PC update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= FETCH;
         op_q      <= OP_ADDI;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         imm_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         imm_q     <= imm_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state and control outputs; datapath controls are only active during EXEC
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      pc_d          = pc_q;
      ir_d          = ir_q;
      imm_d         = imm_q;
      illegal_d     = illegal_q;
      bus.fetch_req = state_q == FETCH;
      bus.we3       = 1'b0;
      bus.alusrc    = 1'b0;
      bus.aluctrl   = 3'b000;
      case (state_q)
         FETCH: begin
            if (bus.instr_valid) begin
               ir_d    = bus.instr;
               state_d = DECODE;
            end
         end
         DECODE: begin
            imm_d     = is_i ? imm_i : is_b ? imm_b : '0;
            op_d      = is_addi ? OP_ADDI : is_add ? OP_ADD : is_sub ? OP_SUB : is_beq ? OP_BEQ : OP_BNE;
            illegal_d = !legal;
            state_d   = legal ? EXEC : TRAP;
         end
         EXEC: begin
            bus.alusrc  = op_q == OP_ADDI;
            bus.aluctrl = (op_q == OP_SUB || op_q == OP_BEQ || op_q == OP_BNE) ? 3'b001 : 3'b000;
            bus.we3     = writes_rd && bus.ad3 != '0;
            pc_d        = taken ? pc_q + imm_q : pc_q + D_WIDTH'(4);
            state_d     = FETCH;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed scoreboard bench for instr_sequencer
module tb_instr_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;
   logic [31:0] pc_m = 32'h0;

`ifdef INSTR_SEQUENCER_BNE_EN
   localparam bit BNE_EN = 1'b1;
`else
   localparam bit BNE_EN = 1'b0;
`endif

   typedef struct {
      logic [4:0]  ad1, ad2, ad3;
      logic [31:0] imm;
      logic        alusrc;
      logic [2:0]  aluctrl;
      logic        we3;
      logic        trap;
      logic [31:0] npc;
   } exp_t;

   exp_t sb[$];

   instr_sequencer_if #(.D_WIDTH(32), .A_WIDTH(5)) bus ();

   instr_sequencer #(.D_WIDTH(32), .A_WIDTH(5), .RESET_PC(32'h0)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic exp_t predict(input logic [31:0] w, input logic e, input logic [31:0] pc);
      exp_t x;
      logic [6:0] op = w[6:0];
      logic [2:0] f3 = w[14:12];
      logic [6:0] f7 = w[31:25];
      logic addi = op == 7'h13 && f3 == 3'd0;
      logic add  = op == 7'h33 && f3 == 3'd0 && f7 == 7'h00;
      logic sub  = op == 7'h33 && f3 == 3'd0 && f7 == 7'h20;
      logic beq  = op == 7'h63 && f3 == 3'd0;
      logic bne  = op == 7'h63 && f3 == 3'd1 && BNE_EN;
      x.ad1     = w[19:15];
      x.ad2     = w[24:20];
      x.ad3     = w[11:7];
      x.imm     = op == 7'h13 ? {{20{w[31]}}, w[31:20]} :
                  op == 7'h63 ? {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0} : 32'h0;
      x.trap    = !(addi || add || sub || beq || bne);
      x.alusrc  = !x.trap && addi;
      x.aluctrl = (!x.trap && (sub || beq || bne)) ? 3'b001 : 3'b000;
      x.we3     = !x.trap && (addi || add || sub) && w[11:7] != 5'd0;
      x.npc     = x.trap ? pc : ((beq && e) || (bne && !e)) ? pc + x.imm : pc + 32'd4;
      return x;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".pc"}, bus.pc, 32'h0);
      chk({tag, ".illegal"}, 32'(bus.illegal), 32'h0);
      chk({tag, ".we3"}, 32'(bus.we3), 32'h0);
      chk({tag, ".fetch_req"}, 32'(bus.fetch_req), 32'h1);
      chk({tag, ".ads"}, {17'h0, bus.ad1, bus.ad2, bus.ad3}, 32'h0);
      chk({tag, ".imm_op"}, bus.imm_op, 32'h0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset(tag);
      @(negedge clk);
      rst = 1'b0;
      pc_m = 32'h0;
   endtask

   task automatic run(input string tag, input logic [31:0] w, input logic e);
      exp_t x;
      int k = 0;
      while (bus.fetch_req !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({tag, ".ready"}, 32'(bus.fetch_req), 32'h1);
      sb.push_back(predict(w, e, pc_m));
      bus.instr       = w;
      bus.instr_valid = 1'b1;
      bus.eq          = e;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.instr       = 32'hDEAD_BEEF;
      chk({tag, ".dec_req"}, 32'(bus.fetch_req), 32'h0);
      chk({tag, ".dec_we3"}, 32'(bus.we3), 32'h0);
      @(negedge clk);
      x = sb.pop_front();
      chk({tag, ".ad1"}, 32'(bus.ad1), 32'(x.ad1));
      chk({tag, ".ad2"}, 32'(bus.ad2), 32'(x.ad2));
      chk({tag, ".ad3"}, 32'(bus.ad3), 32'(x.ad3));
      chk({tag, ".imm_op"}, bus.imm_op, x.imm);
      chk({tag, ".alusrc"}, 32'(bus.alusrc), 32'(x.alusrc));
      chk({tag, ".aluctrl"}, 32'(bus.aluctrl), 32'(x.aluctrl));
      chk({tag, ".we3"}, 32'(bus.we3), 32'(x.we3));
      chk({tag, ".illegal"}, 32'(bus.illegal), 32'(x.trap));
      chk({tag, ".ex_req"}, 32'(bus.fetch_req), 32'h0);
      @(negedge clk);
      chk({tag, ".pc"}, bus.pc, x.npc);
      chk({tag, ".post_we3"}, 32'(bus.we3), 32'h0);
      chk({tag, ".post_req"}, 32'(bus.fetch_req), 32'(!x.trap));
      pc_m = x.npc;
   endtask

   initial begin
      bus.instr       = 32'h0;
      bus.instr_valid = 1'b0;
      bus.eq          = 1'b0;
      #1;
      chk_reset("por");
      repeat (2) @(negedge clk);
      chk_reset("por_hold");
      rst = 1'b0;

      run("addi_x1_5",   32'h00500093, 1'b0);
      run("sub_x3",      32'h402081B3, 1'b0);
      run("beq_taken",   32'h00208463, 1'b1);
      run("addi_x0",     32'h00100013, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle.req", 32'(bus.fetch_req), 32'h1);
         chk("idle.pc", bus.pc, pc_m);
      end
      run("add_x5",      32'h007302B3, 1'b0);
      run("addi_neg",    32'hFFF00113, 1'b0);

      do_reset("rst1");
      run("beq_back",    32'hFE000EE3, 1'b1);
      run("addi_wrap",   32'h00100013, 1'b0);
      run("addi_x0_b",   32'h00100013, 1'b0);
      run("addi_x0_c",   32'h00100013, 1'b0);
      run("beq_not",     32'h00208463, 1'b0);

      run("illegal",     32'hFFFFFFFF, 1'b0);
      bus.instr       = 32'h00500093;
      bus.instr_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("trap.req", 32'(bus.fetch_req), 32'h0);
         chk("trap.pc", bus.pc, pc_m);
         chk("trap.illegal", 32'(bus.illegal), 32'h1);
         chk("trap.we3", 32'(bus.we3), 32'h0);
      end
      bus.instr_valid = 1'b0;
      do_reset("rst2");

      bus.instr       = 32'h00500093;
      bus.instr_valid = 1'b1;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      @(negedge clk);
      chk("midexec.we3_before", 32'(bus.we3), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("midexec.we3", 32'(bus.we3), 32'h0);
      chk("midexec.pc", bus.pc, 32'h0);
      @(negedge clk);
      chk("midexec.pc_hold", bus.pc, 32'h0);
      rst  = 1'b0;
      pc_m = 32'h0;

      run("bne_x1_x2",   32'h00209463, 1'b0);
      do_reset("rst3");
      run("addi_after",  32'h00500093, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
